// File: rtl/huffman_code_decoder.sv
// Serial Huffman decoder: shifts code bits in MSB-first, matches the accumulated
// prefix against a 7-entry code table in parallel and emits symbol indices 1..7.
module huffman_code_decoder #(
  parameter int unsigned CODE_W  = 8,
  parameter int unsigned LEN_W   = 3,
  parameter int unsigned MAX_LEN = 7
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic [CODE_W-1:0] code_1,
  input  logic [CODE_W-1:0] code_2,
  input  logic [CODE_W-1:0] code_3,
  input  logic [CODE_W-1:0] code_4,
  input  logic [CODE_W-1:0] code_5,
  input  logic [CODE_W-1:0] code_6,
  input  logic [CODE_W-1:0] code_7,
  input  logic [LEN_W-1:0]  len_1,
  input  logic [LEN_W-1:0]  len_2,
  input  logic [LEN_W-1:0]  len_3,
  input  logic [LEN_W-1:0]  len_4,
  input  logic [LEN_W-1:0]  len_5,
  input  logic [LEN_W-1:0]  len_6,
  input  logic [LEN_W-1:0]  len_7,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic [2:0]        sym_out,
  output logic              sym_valid,
  input  logic              sym_ready,
  output logic              err
);

  localparam int unsigned NUM_SYM = 7;
  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

  logic [CODE_W-1:0] code_tab [NUM_SYM];
  logic [LEN_W-1:0]  len_tab  [NUM_SYM];

  // The top shift-register bit would fall out on the next shift, so only CODE_W-1 are kept.
  logic [CODE_W-2:0] acc_q, acc_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        sym_q, sym_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic [CODE_W-1:0] next_acc;
  logic [LEN_W-1:0]  next_cnt;
  logic              hit;
  logic [2:0]        hit_sym;
  logic              accept;

  always_comb begin
    code_tab[0] = code_1;
    code_tab[1] = code_2;
    code_tab[2] = code_3;
    code_tab[3] = code_4;
    code_tab[4] = code_5;
    code_tab[5] = code_6;
    code_tab[6] = code_7;
    len_tab[0]  = len_1;
    len_tab[1]  = len_2;
    len_tab[2]  = len_3;
    len_tab[3]  = len_4;
    len_tab[4]  = len_5;
    len_tab[5]  = len_6;
    len_tab[6]  = len_7;
  end

  assign bit_ready = nRST && en && (!valid_q || sym_ready);
  assign accept    = bit_valid && bit_ready;
  assign next_acc  = {acc_q, bit_in};
  assign next_cnt  = cnt_q + LEN_W'(1);

  // Parallel compare; scanning downward lets the lowest matching index win.
  always_comb begin
    hit     = 1'b0;
    hit_sym = 3'd0;
    for (int i = NUM_SYM - 1; i >= 0; i--) begin
      if ((len_tab[i] != '0) && (len_tab[i] == next_cnt) &&
          (((code_tab[i] ^ next_acc) & ~({CODE_W{1'b1}} << len_tab[i])) == '0)) begin
        hit     = 1'b1;
        hit_sym = 3'(i + 1);
      end
    end
  end

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sym_d   = sym_q;
    valid_d = valid_q && !sym_ready;
    err_d   = 1'b0;
    if (!en) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      if (hit) begin
        sym_d   = hit_sym;
        valid_d = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
      end else if (next_cnt == MAX_CNT) begin
        err_d = 1'b1;
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = next_acc[CODE_W-2:0];
        cnt_d = next_cnt;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      sym_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sym_q   <= sym_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign sym_out   = sym_q;
  assign sym_valid = valid_q;
  assign err       = err_q;

endmodule
